// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8 x WIDTH register file.
// Two writeback requesters (0 = ALU, 1 = memory-load return) share one port.
// Round-robin between requesters, with optional locked bursts of at most
// LOCK_MAX consecutive transfers. Grants are combinational; the write strobe,
// write data and owner view are registered.
module regfile_write_arbiter #(
   parameter int WIDTH    = 16,
   parameter int LOCK_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [2:0]       addr0,
   input  logic [2:0]       addr1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic             lock0,
   input  logic             lock1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [7:0]       writeEnable,
   output logic [WIDTH-1:0] writeData,
   output logic [1:0]       owner
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } stateT;

   // A lock of a single cycle is the same as no lock at all.
   localparam bit CanLock = (LOCK_MAX > 1);
   localparam logic [3:0] LockLast = 4'(LOCK_MAX);

   stateT      state;
   logic       rr;
   logic [3:0] lcnt;
   logic       grant0;
   logic       grant1;
   logic [7:0] decode0;
   logic [7:0] decode1;

   // Grant selection: round-robin in IDLE, owner-only while a lock is held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case (state)
         IDLE: begin
            grant0 = req0 & (~req1 | ~rr);
            grant1 = req1 & (~req0 | rr);
         end
         OWN0:    grant0 = req0;
         OWN1:    grant1 = req1;
         default: ;
      endcase
   end

   // Grants are forced low while reset is held.
   assign gnt0 = rst & grant0;
   assign gnt1 = rst & grant1;

   // One-hot decode of each requester's target register.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : genDecode
         assign decode0[gi] = (addr0 == 3'(gi));
         assign decode1[gi] = (addr1 == 3'(gi));
      end
   endgenerate

   // Ownership state machine with round-robin pointer, lock counter and owner view.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         owner <= 2'b00;
         rr    <= 1'b0;
         lcnt  <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt0) begin
                  rr <= 1'b1;
                  if (lock0 && CanLock) begin
                     state <= OWN0;
                     owner <= 2'b01;
                     lcnt  <= 4'd1;
                  end
               end else if (gnt1) begin
                  rr <= 1'b0;
                  if (lock1 && CanLock) begin
                     state <= OWN1;
                     owner <= 2'b10;
                     lcnt  <= 4'd1;
                  end
               end
            end
            OWN0: begin
               // Release on idle owner, unlocked transfer, or burst limit reached.
               if (!gnt0 || !lock0 || (lcnt + 4'd1 == LockLast)) begin
                  state <= IDLE;
                  owner <= 2'b00;
                  rr    <= 1'b1;
                  lcnt  <= 4'd0;
               end else begin
                  lcnt <= lcnt + 4'd1;
               end
            end
            OWN1: begin
               if (!gnt1 || !lock1 || (lcnt + 4'd1 == LockLast)) begin
                  state <= IDLE;
                  owner <= 2'b00;
                  rr    <= 1'b0;
                  lcnt  <= 4'd0;
               end else begin
                  lcnt <= lcnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               owner <= 2'b00;
               lcnt  <= 4'd0;
            end
         endcase
      end
   end

   // Registered write path: strobe for one cycle per transfer, data holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         writeEnable <= 8'd0;
         writeData   <= '0;
      end else if (gnt0) begin
         writeEnable <= decode0;
         writeData   <= data0;
      end else if (gnt1) begin
         writeEnable <= decode1;
         writeData   <= data1;
      end else begin
         writeEnable <= 8'd0;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural ownership/regfile model.
module tb_regfile_write_arbiter;

   localparam int WIDTH    = 16;
   localparam int LOCK_MAX = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req0 = 1'b0, req1 = 1'b0;
   logic [2:0]       addr0 = 3'd0, addr1 = 3'd0;
   logic [WIDTH-1:0] data0 = '0, data1 = '0;
   logic             lock0 = 1'b0, lock1 = 1'b0;
   logic             gnt0, gnt1;
   logic [7:0]       writeEnable;
   logic [WIDTH-1:0] writeData;
   logic [1:0]       owner;

   regfile_write_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1),
      .data0(data0), .data1(data1),
      .lock0(lock0), .lock1(lock1),
      .gnt0(gnt0), .gnt1(gnt1),
      .writeEnable(writeEnable), .writeData(writeData),
      .owner(owner)
   );

   always #5 clk = ~clk;

   // Register file fed by the DUT strobe, as the register_16bits instances would be.
   logic [WIDTH-1:0] rf [8];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++) if (writeEnable[i]) rf[i] <= writeData;
      end
   end

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the port, tie-break pointer, burst length, regfile.
   int               mOwn = -1;
   bit               mRr = 1'b0;
   int               mCnt = 0;
   logic [7:0]       mWe = 8'd0;
   logic [WIDTH-1:0] mWd = '0;
   logic [WIDTH-1:0] expRf [8];
   bit               pendV = 1'b0;
   int               pendA = 0;
   logic [WIDTH-1:0] pendD = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mOwn = -1; mRr = 1'b0; mCnt = 0; mWe = 8'd0; mWd = '0; pendV = 1'b0;
      for (int i = 0; i < 8; i++) expRf[i] = '0;
   endtask

   task automatic modelRelease();
      mRr  = (mOwn == 0);
      mOwn = -1;
      mCnt = 0;
   endtask

   // One clock cycle: drive inputs, check grants, advance model, check registered outputs.
   task automatic step(input logic r0, input logic [2:0] a0, input logic [WIDTH-1:0] d0,
                       input logic l0, input logic r1, input logic [2:0] a1,
                       input logic [WIDTH-1:0] d1, input logic l1, output int winner);
      int               a;
      logic [WIDTH-1:0] d;
      logic             l;
      req0 = r0; addr0 = a0; data0 = d0; lock0 = l0;
      req1 = r1; addr1 = a1; data1 = d1; lock1 = l1;
      #1;
      if (mOwn < 0) winner = (r0 && r1) ? int'(mRr) : r0 ? 0 : r1 ? 1 : -1;
      else          winner = ((mOwn == 0) ? r0 : r1) ? mOwn : -1;
      chk("gnt0", 32'(gnt0), 32'(winner == 0));
      chk("gnt1", 32'(gnt1), 32'(winner == 1));
      @(posedge clk);
      if (pendV) expRf[pendA] = pendD;
      pendV = 1'b0;
      a = (winner == 1) ? int'(a1) : int'(a0);
      d = (winner == 1) ? d1 : d0;
      l = (winner == 1) ? l1 : l0;
      if (winner >= 0) begin
         mWe = 8'd1 << a; mWd = d;
         pendV = 1'b1; pendA = a; pendD = d;
      end else begin
         mWe = 8'd0;
      end
      if (mOwn < 0) begin
         if (winner >= 0) begin
            mRr = (winner == 0);
            if (l && LOCK_MAX > 1) begin mOwn = winner; mCnt = 1; end
         end
      end else if (winner < 0) begin
         modelRelease();
      end else begin
         mCnt++;
         if (!l || mCnt == LOCK_MAX) modelRelease();
      end
      #1;
      chk("writeEnable", 32'(writeEnable), 32'(mWe));
      chk("writeData", 32'(writeData), 32'(mWd));
      chk("owner", 32'(owner), (mOwn < 0) ? 32'd0 : (mOwn == 0) ? 32'd1 : 32'd2);
   endtask

   task automatic idle(output int w);
      step(1'b0, 3'd0, '0, 1'b0, 1'b0, 3'd0, '0, 1'b0, w);
   endtask

   initial begin
      int w;
      int wins [6];
      modelReset();
      // Reset state
      #2;
      chk("rst_we", 32'(writeEnable), 32'd0);
      chk("rst_wd", 32'(writeData), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      req0 = 1'b1; req1 = 1'b1; #1;
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_gnt1", 32'(gnt1), 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;

      // Single write from requester 0
      step(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 3'd0, '0, 1'b0, w);
      chk("single_gnt", 32'(w), 32'd0);
      chk("single_we", 32'(writeEnable), 32'h08);
      chk("single_wd", 32'(writeData), 32'hBEEF);
      idle(w);
      chk("single_we_clear", 32'(writeEnable), 32'd0);

      // Bring rr back to 0, then alternate under constant contention
      step(1'b0, 3'd0, '0, 1'b0, 1'b1, 3'd1, 16'h1111, 1'b0, w);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b0, 1'b1, 3'(i + 4), 16'hB000 + 16'(i), 1'b0, w);
         chk("alt_order", 32'(w), 32'(i % 2));
         chk("alt_we_nonzero", 32'(writeEnable != 8'd0), 32'd1);
      end

      // Locked burst by requester 1 against a persistent requester 0
      step(1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 3'd0, '0, 1'b0, w);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 3'd0, 16'hC000 + 16'(i), 1'b0, 1'b1, 3'd7, 16'hD000 + 16'(i), 1'b1, w);
         wins[i] = w;
         if (i < 3) chk("lock_owner10", 32'(owner), 32'd2);
         if (i == 3) chk("lock_forced_release", 32'(owner), 32'd0);
      end
      for (int i = 0; i < 4; i++) chk("lock_gnt1", 32'(wins[i]), 32'd1);
      chk("lock_then_gnt0", 32'(wins[4]), 32'd0);
      idle(w);

      // Same address from both requesters: arbitration orders the two writes
      step(1'b1, 3'd5, 16'h0001, 1'b0, 1'b1, 3'd5, 16'h0002, 1'b0, w);
      chk("same_first", 32'(w), 32'd0);
      step(1'b0, 3'd0, '0, 1'b0, 1'b1, 3'd5, 16'h0002, 1'b0, w);
      chk("same_second", 32'(w), 32'd1);
      chk("same_rf5_first", 32'(rf[5]), 32'h0001);
      idle(w);
      chk("same_rf5_second", 32'(rf[5]), 32'h0002);

      // Reset in the middle of a locked burst with a strobe pending
      step(1'b1, 3'd6, 16'h6666, 1'b1, 1'b0, 3'd0, '0, 1'b0, w);
      chk("burst_owner01", 32'(owner), 32'd1);
      chk("burst_strobe", 32'(writeEnable), 32'h40);
      rst = 1'b0;
      #1;
      chk("midrst_we", 32'(writeEnable), 32'd0);
      chk("midrst_gnt0", 32'(gnt0), 32'd0);
      chk("midrst_owner", 32'(owner), 32'd0);
      modelReset();
      req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
      #2;
      rst = 1'b1;
      step(1'b1, 3'd1, 16'h0A0A, 1'b0, 1'b1, 3'd2, 16'h0B0B, 1'b0, w);
      chk("postrst_gnt0", 32'(w), 32'd0);

      // Owner 0 idles one cycle while requester 1 waits
      step(1'b1, 3'd4, 16'h4444, 1'b1, 1'b0, 3'd0, '0, 1'b0, w);
      chk("own0_enter", 32'(owner), 32'd1);
      step(1'b0, 3'd0, '0, 1'b0, 1'b1, 3'd3, 16'h3333, 1'b0, w);
      chk("own0_blocks_gnt1", 32'(w), -32'sd1);
      chk("own0_release", 32'(owner), 32'd0);
      step(1'b0, 3'd0, '0, 1'b0, 1'b1, 3'd3, 16'h3333, 1'b0, w);
      chk("after_release_gnt1", 32'(w), 32'd1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom), 1'($urandom),
              1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom), 1'($urandom), w);
      end
      idle(w);
      idle(w);
      for (int i = 0; i < 8; i++) chk("regfile", 32'(rf[i]), 32'(expRf[i]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 8 x 16-bit register file between two writeback requesters: requester 0 is the ALU writeback and requester 1 is the multi-cycle memory-load return. The arbiter grants requesters round-robin and supports bounded locked bursts. It drives a registered one-hot write-enable vector and a write-data bus directly into the eight `register_16bits` instances.

## Interface
- `WIDTH`, 16: data width of every register and of the write bus.
- `LOCK_MAX`, 4: maximum consecutive cycles a requester may hold a lock, 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to `clk` upstream.
- `req0`, `req1` in 1: write request from requester 0 / 1.
- `addr0`, `addr1` in 3: target register index.
- `data0`, `data1` in WIDTH: write data.
- `lock0`, `lock1` in 1: keep ownership after this transfer; sampled only on a granted transfer.
- `gnt0`, `gnt1` out 1: combinational grant. Transfer occurs on a rising edge where `reqX & gntX`.
- `writeEnable` out 8: registered one-hot register write strobe.
- `writeData` out WIDTH: registered write data.
- `owner` out 2: registered debug view of the state. 00 IDLE, 01 OWN0, 10 OWN1.

## Operation
- State machine states: IDLE, OWN0, OWN1. A 1-bit round-robin pointer `rr` names the requester that wins the next tie.
- Lock counter `lcnt` is 4 bits wide.
- IDLE:
  - Only `req0`: `gnt0` = 1.
  - Only `req1`: `gnt1` = 1.
  - Both: grant the requester named by `rr`.
  - Neither: no grant.
- Granted transfer by X in IDLE:
  - `rr` <= ~X.
  - If `lockX` = 1 and LOCK_MAX > 1: go to OWNX with `lcnt` = 1.
  - Otherwise stay in IDLE.
- OWNX:
  - `gntX` = `reqX`. The other grant is 0 regardless of its request.
  - Each granted transfer increments `lcnt`.
- Exit from OWNX to IDLE occurs on the edge of any of these:
  - a granted transfer with `lockX` = 0;
  - `reqX` = 0 for a cycle (an idle owner releases);
  - a transfer that brings `lcnt` to LOCK_MAX (forced release).
- On exit: `rr` <= ~X and `lcnt` <= 0.
- Write path, on every edge:
  - On a transfer by X: `writeEnable` <= one-hot decode of `addrX` and `writeData` <= `dataX`.
  - With no transfer: `writeEnable` <= 0 and `writeData` holds its previous value.
- At most one bit of `writeEnable` is set in any cycle, and both grants are never 1 together.
- Same-address requests in the same cycle are resolved purely by arbitration. The loser writes later, so the last write to reach the register wins.
- `addrX` and `dataX` are don't-care while `reqX` = 0.

## Timing
- Reset values while `rst` = 0:
  - `writeEnable` = 0, `writeData` = 0, `owner` = 00.
  - State IDLE, `rr` = 0, `lcnt` = 0.
  - `gnt0` = `gnt1` = 0 (grants are gated by `rst`).
- Reset mid-burst or with a write pending: the pending strobe clears asynchronously and the write is dropped. After release the block restarts in IDLE with requester 0 favoured.
- Grant latency: 0 cycles, combinational from `req` and state.
- Write latency: a transfer at edge N drives `writeEnable`/`writeData` during cycle N to N+1. The register captures the data at edge N+1, so it becomes readable after edge N+1.
- Throughput: one write per cycle, including back-to-back alternation between requesters.
- Worst-case wait for a requesting, non-owner requester: LOCK_MAX + 1 cycles.
- `owner` updates on the same edge as the state.

## Test plan
- Reset, then `req0` = 1, `addr0` = 3, `data0` = 16'hBEEF for one cycle. Required: `gnt0` = 1 in that cycle; the next cycle `writeEnable` = 8'b0000_1000 and `writeData` = 16'hBEEF; the cycle after, `writeEnable` = 0.
- `req0` = `req1` = 1 held for 4 cycles, no locks. Required: grants alternate 0, 1, 0, 1; `writeEnable` is never zero during the write cycles that follow.
- `req1` with `lock1` = 1 for 6 cycles while `req0` = 1, LOCK_MAX = 4. Required: `gnt1` for exactly 4 cycles, `owner` = 10 for 3 cycles, then `gnt0` = 1 on cycle 5.
- Both request `addr` = 5 with `data0` = 16'h0001 and `data1` = 16'h0002, `rr` = 0. Required: register 5 is written with 16'h0001, then with 16'h0002 one cycle later.
- `rst` pulled low mid-burst with `owner` = 01 and a write strobe active. Required: `writeEnable`, `gnt0` and `owner` go to 0 within the same cycle; after release, a simultaneous request grants requester 0.
- Owner OWN0 drops `req0` for one cycle while `req1` = 1. Required: state returns to IDLE and `gnt1` = 1 in the following cycle.
